// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy/tag scoreboard.
// Reads are combinational with same-cycle writeback bypass; issue, writeback and flush commit on clk_in.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int TAGW = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    r_addr,
    output logic [NRD*XLEN-1:0]  r_data,
    output logic [NRD-1:0]       r_busy,
    output logic [NRD*TAGW-1:0]  r_tag,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic [TAGW-1:0]      iss_tag,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [TAGW-1:0]      wb_tag,
    input  logic                 flush_in,
    output logic [AW:0]          busy_cnt
);

    logic [XLEN-1:0] r_regs      [NREG];
    logic            r_busy_bits [NREG];
    logic [TAGW-1:0] r_tags      [NREG];
    logic [AW:0]     r_cnt;

    logic w_iss_ok;
    logic w_wb_ok;
    logic w_wb_clear;
    logic w_cnt_inc;
    logic w_cnt_dec;

    assign w_iss_ok   = rdy_in && iss_en && (iss_addr != '0) && !flush_in;
    assign w_wb_ok    = rdy_in && wb_en && (wb_addr != '0);
    assign w_wb_clear = w_wb_ok && r_busy_bits[wb_addr] && (r_tags[wb_addr] == wb_tag);
    assign w_cnt_inc  = w_iss_ok && !r_busy_bits[iss_addr];
    // A same-register issue keeps the bit set, so the matching writeback does not decrement.
    assign w_cnt_dec  = w_wb_clear && !(w_iss_ok && (iss_addr == wb_addr));

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_regs[gi]      <= '0;
                    r_busy_bits[gi] <= 1'b0;
                    r_tags[gi]      <= '0;
                end else if (rdy_in) begin
                    if (w_wb_ok && (wb_addr == AW'(gi)))
                        r_regs[gi] <= wb_data;
                    if (flush_in) begin
                        r_busy_bits[gi] <= 1'b0;
                        r_tags[gi]      <= '0;
                    end else if (w_iss_ok && (iss_addr == AW'(gi))) begin
                        r_busy_bits[gi] <= 1'b1;
                        r_tags[gi]      <= iss_tag;
                    end else if (w_wb_clear && (wb_addr == AW'(gi))) begin
                        r_busy_bits[gi] <= 1'b0;
                        r_tags[gi]      <= '0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (rdy_in) begin
            if (flush_in)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + {{AW{1'b0}}, w_cnt_inc} - {{AW{1'b0}}, w_cnt_dec};
        end
    end

    assign busy_cnt = r_cnt;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_busy;
            logic [TAGW-1:0] w_tag;

            assign w_addr = r_addr[gi*AW +: AW];

            always_comb begin
                w_data = '0;
                w_busy = 1'b0;
                w_tag  = '0;
                if (rdy_in && re[gi] && (w_addr != '0)) begin
                    // Forward a writeback that will retire (or write an idle) register this cycle.
                    if (wb_en && (wb_addr == w_addr) &&
                        (!r_busy_bits[w_addr] || (r_tags[w_addr] == wb_tag))) begin
                        w_data = wb_data;
                    end else begin
                        w_data = r_regs[w_addr];
                        w_busy = r_busy_bits[w_addr];
                        w_tag  = r_busy_bits[w_addr] ? r_tags[w_addr] : '0;
                    end
                end
            end

            assign r_data[gi*XLEN +: XLEN] = w_data;
            assign r_busy[gi]              = w_busy;
            assign r_tag[gi*TAGW +: TAGW]  = w_tag;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based scoreboard model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int TAGW = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 rdy_in;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    r_addr;
    logic [NRD*XLEN-1:0]  r_data;
    logic [NRD-1:0]       r_busy;
    logic [NRD*TAGW-1:0]  r_tag;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [TAGW-1:0]      iss_tag;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic [TAGW-1:0]      wb_tag;
    logic                 flush_in;
    logic [AW:0]          busy_cnt;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .TAGW(TAGW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .re(re), .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy), .r_tag(r_tag),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_tag(wb_tag),
        .flush_in(flush_in), .busy_cnt(busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Reference state: plain arrays updated from the behavioural rules.
    logic [XLEN-1:0] m_data [NREG];
    bit              m_busy [NREG];
    logic [TAGW-1:0] m_tag  [NREG];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic void model_read(input logic [AW-1:0] a, input logic en,
                                       output logic [XLEN-1:0] d, output logic b,
                                       output logic [TAGW-1:0] t);
        d = '0; b = 1'b0; t = '0;
        if (rdy_in && en && a != 0) begin
            if (wb_en && wb_addr == a && (!m_busy[a] || m_tag[a] == wb_tag)) begin
                d = wb_data;
            end else begin
                d = m_data[a];
                b = m_busy[a];
                t = m_busy[a] ? m_tag[a] : '0;
            end
        end
    endfunction

    function automatic void model_clock();
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                m_data[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
            end
        end else if (rdy_in) begin
            if (wb_en && wb_addr != 0) begin
                m_data[wb_addr] = wb_data;
                if (!flush_in && m_busy[wb_addr] && m_tag[wb_addr] == wb_tag) begin
                    m_busy[wb_addr] = 0; m_tag[wb_addr] = '0;
                end
            end
            if (flush_in) begin
                for (int i = 0; i < NREG; i++) begin
                    m_busy[i] = 0; m_tag[i] = '0;
                end
            end else if (iss_en && iss_addr != 0) begin
                m_busy[iss_addr] = 1; m_tag[iss_addr] = iss_tag;
            end
        end
    endfunction

    task automatic idle();
        rst_in = 0; rdy_in = 1; iss_en = 0; wb_en = 0; flush_in = 0;
        iss_addr = '0; iss_tag = '0; wb_addr = '0; wb_data = '0; wb_tag = '0;
    endtask

    task automatic set_read(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        re = en; r_addr = {a1, a0};
    endtask

    // Compare all outputs with the model at the falling edge.
    task automatic sample(input string note);
        logic [XLEN-1:0] d;
        logic            b;
        logic [TAGW-1:0] t;
        @(negedge clk_in);
        $display("[TB] %s rst=%0b rdy=%0b iss=%0b/%0d/%0d wb=%0b/%0d/%0h/%0d fl=%0b rd=%0d,%0d cnt=%0d",
                 note, rst_in, rdy_in, iss_en, iss_addr, iss_tag, wb_en, wb_addr, wb_data, wb_tag,
                 flush_in, r_addr[AW-1:0], r_addr[2*AW-1:AW], busy_cnt);
        for (int k = 0; k < NRD; k++) begin
            model_read(r_addr[k*AW +: AW], re[k], d, b, t);
            check($sformatf("%s.rd%0d_data", note, k), 64'(r_data[k*XLEN +: XLEN]), 64'(d));
            check($sformatf("%s.rd%0d_busy", note, k), 64'(r_busy[k]), 64'(b));
            check($sformatf("%s.rd%0d_tag", note, k), 64'(r_tag[k*TAGW +: TAGW]), 64'(t));
        end
        check($sformatf("%s.busy_cnt", note), 64'(busy_cnt), 64'(model_count()));
    endtask

    task automatic advance();
        @(posedge clk_in);
        model_clock();
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_data[i] = 'x; m_busy[i] = 0; m_tag[i] = '0;
        end
        idle();
        set_read(2'b00, 0, 0);
        rst_in = 1;
        advance();
        advance();

        idle();
        set_read(2'b11, 5, 0);
        sample("reset_rd");
        check("reset.x5_data", 64'(r_data[31:0]), 64'h0);
        check("reset.x0_busy", 64'(r_busy), 64'h0);
        check("reset.cnt", 64'(busy_cnt), 64'h0);
        advance();

        idle(); iss_en = 1; iss_addr = 3; iss_tag = 7;
        sample("iss_x3"); advance();
        idle(); set_read(2'b11, 3, 3);
        sample("rd_x3");
        check("x3.busy", 64'(r_busy[0]), 64'h1);
        check("x3.tag", 64'(r_tag[3:0]), 64'h7);
        check("x3.cnt", 64'(busy_cnt), 64'h1);
        advance();
        wb_en = 1; wb_addr = 3; wb_tag = 7; wb_data = 32'hDEADBEEF;
        sample("wb_x3");
        check("x3.bypass", 64'(r_data[31:0]), 64'hDEADBEEF);
        check("x3.bypass_busy", 64'(r_busy[0]), 64'h0);
        advance();
        idle();
        sample("x3_done");
        check("x3.cnt_after", 64'(busy_cnt), 64'h0);
        advance();

        idle(); iss_en = 1; iss_addr = 4; iss_tag = 1; set_read(2'b01, 4, 0);
        sample("iss_x4_t1"); advance();
        iss_tag = 2;
        sample("iss_x4_t2"); advance();
        idle(); wb_en = 1; wb_addr = 4; wb_tag = 1; wb_data = 32'h11;
        sample("wb_x4_stale");
        check("x4.stale_busy", 64'(r_busy[0]), 64'h1);
        check("x4.stale_tag", 64'(r_tag[3:0]), 64'h2);
        advance();
        idle(); wb_en = 1; wb_addr = 4; wb_tag = 2; wb_data = 32'h22;
        sample("wb_x4_t2");
        check("x4.final_data", 64'(r_data[31:0]), 64'h22);
        check("x4.final_busy", 64'(r_busy[0]), 64'h0);
        advance();

        idle(); iss_en = 1; iss_addr = 6; iss_tag = 3; set_read(2'b01, 6, 0);
        sample("iss_x6"); advance();
        idle(); wb_en = 1; wb_addr = 6; wb_tag = 3; wb_data = 32'hABCD;
        iss_en = 1; iss_addr = 6; iss_tag = 5;
        sample("wb_iss_x6"); advance();
        idle();
        sample("rd_x6");
        check("x6.data", 64'(r_data[31:0]), 64'hABCD);
        check("x6.busy", 64'(r_busy[0]), 64'h1);
        check("x6.tag", 64'(r_tag[3:0]), 64'h5);
        check("x6.cnt", 64'(busy_cnt), 64'h1);
        advance();

        idle(); iss_en = 1; iss_addr = 1; sample("iss_x1"); advance();
        iss_addr = 2; sample("iss_x2"); advance();
        iss_addr = 9; sample("iss_x9"); advance();
        idle(); flush_in = 1; iss_en = 1; iss_addr = 10; iss_tag = 4;
        wb_en = 1; wb_addr = 2; wb_data = 32'h55; wb_tag = 9;
        sample("flush"); advance();
        idle(); set_read(2'b11, 2, 10);
        sample("post_flush");
        check("flush.x2_data", 64'(r_data[31:0]), 64'h55);
        check("flush.x10_busy", 64'(r_busy[1]), 64'h0);
        check("flush.cnt", 64'(busy_cnt), 64'h0);
        advance();

        idle(); wb_en = 1; wb_addr = 7; wb_data = 32'h77; sample("wb_x7"); advance();
        idle(); rdy_in = 0; wb_en = 1; wb_addr = 7; wb_data = 32'h99;
        iss_en = 1; iss_addr = 8; iss_tag = 6; set_read(2'b11, 7, 8);
        sample("rdy_low");
        check("rdy_low.data", 64'(r_data), 64'h0);
        advance();
        idle();
        sample("rdy_high");
        check("rdy.x7_data", 64'(r_data[31:0]), 64'h77);
        check("rdy.x8_busy", 64'(r_busy[1]), 64'h0);
        advance();

        idle(); iss_en = 1; iss_addr = 5; iss_tag = 3; sample("iss_x5"); advance();
        idle(); rst_in = 1; wb_en = 1; wb_addr = 11; wb_data = 32'hCAFE; set_read(2'b11, 11, 5);
        sample("mid_reset"); advance();
        idle();
        sample("after_reset");
        check("rst.x11_data", 64'(r_data[31:0]), 64'h0);
        check("rst.x5_busy", 64'(r_busy[1]), 64'h0);
        check("rst.cnt", 64'(busy_cnt), 64'h0);
        advance();

        for (int n = 0; n < 300; n++) begin
            rst_in   = ($urandom_range(0, 127) == 0);
            rdy_in   = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 31) == 0);
            iss_en   = $urandom_range(0, 1);
            iss_addr = AW'($urandom_range(0, 7));
            iss_tag  = TAGW'($urandom_range(0, 3));
            wb_en    = $urandom_range(0, 1);
            wb_addr  = AW'($urandom_range(0, 7));
            wb_tag   = TAGW'($urandom_range(0, 3));
            wb_data  = $urandom;
            set_read(2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            sample($sformatf("rnd%0d", n));
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated per-register busy/tag scoreboard, replacing the fixed two-read-port, 32×32 register file in the CPU core. Decode reads operands through NRD independent read ports and learns whether each operand is still pending and under which producer tag. Issue marks destinations busy, writeback retires them with tag matching, and flush clears all pending state on a pipeline redirect. The block sits between decode/issue and the writeback bus.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two)
- AW, 5, register address width (log2 NREG)
- NRD, 2, number of read ports
- TAGW, 4, producer tag width
- clk_in  in  1  clock, all state updates on rising edge
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- re  in  NRD  per-port read enable
- r_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- r_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- r_busy  out  NRD  operand still pending
- r_tag  out  NRD*TAGW  tag of pending producer (0 when not busy)
- iss_en  in  1  mark iss_addr busy
- iss_addr  in  AW  destination register being issued
- iss_tag  in  TAGW  producer tag of the issued instruction
- wb_en  in  1  writeback valid
- wb_addr  in  AW  writeback destination
- wb_data  in  XLEN  writeback value
- wb_tag  in  TAGW  tag of the producing instruction
- flush_in  in  1  clear all busy bits
- busy_cnt  out  AW+1  registered count of busy registers

## Operation
- State: data[NREG], busy[NREG], tag[NREG]. Register 0 reads as 0, never busy; issue or writeback to address 0 is ignored.
- Writeback (wb_en, wb_addr≠0): data[wb_addr] <= wb_data unconditionally. busy[wb_addr] cleared only if busy and tag[wb_addr]==wb_tag; a mismatching tag (stale producer superseded by a newer issue) writes data but leaves busy/tag unchanged.
- Issue (iss_en, iss_addr≠0, no flush): busy <= 1, tag <= iss_tag, overriding any clear from a same-cycle writeback to the same register.
- Flush: all busy <= 0, tags <= 0; same-cycle writeback still writes data; same-cycle issue is dropped.
- Read port k, combinational: if !rdy_in, !re[k] or r_addr==0 -> data 0, busy 0, tag 0. Else if wb_en, wb_addr==r_addr and (!busy[r_addr] or tag==wb_tag) -> bypass wb_data, busy 0, tag 0. Else data[r_addr], busy[r_addr], tag[r_addr] (tag forced 0 when not busy).
- Issue in the current cycle is not visible to reads until the next cycle.
- busy_cnt: registered; next = current + (issue sets a previously clear bit) − (writeback clears a bit); flush -> 0. Never exceeds NREG−1.
- rdy_in low: no state changes (writes, issue, flush, counter all ignored); read outputs 0.

## Timing
- Reset (rst_in high at clock edge, regardless of rdy_in): all data 0, all busy 0, all tags 0, busy_cnt 0. Read outputs 0 during reset cycle follow combinational rules on cleared state.
- Read latency 0 cycles (combinational); write/issue/flush take effect at the next rising edge.
- Writeback-to-read forwarding: same cycle via bypass.
- Issue-then-read: busy visible 1 cycle after iss_en.
- Reset asserted mid-sequence discards all pending busy state; no partial writes survive.

## Test plan
- Reset, then read x5 and x0 on both ports -> r_data 0, r_busy 0, busy_cnt 0.
- Issue x3 tag 7; next cycle read x3 -> r_busy 1, r_tag 7, busy_cnt 1; writeback x3 tag 7 data 0xDEADBEEF same cycle as read -> r_data 0xDEADBEEF, r_busy 0; next cycle busy_cnt 0.
- Issue x4 tag 1, then x4 tag 2; writeback x4 tag 1 data 0x11 -> x4 still busy tag 2, data reads 0x11 only after tag-2 writeback with 0x22 -> data 0x22, busy 0.
- Same cycle: writeback x6 tag 3 (matching) and issue x6 tag 5 -> next cycle x6 data = wb value, busy 1, tag 5, busy_cnt unchanged.
- Issue x1, x2, x9; assert flush_in with issue x10 and writeback x2 data 0x55 -> next cycle all busy 0, busy_cnt 0, x2 reads 0x55, x10 not busy.
- Hold rdy_in low while driving writeback x7 0x99 and issue x8 -> outputs 0, no state change; after rdy_in high x7 reads old value, x8 not busy.
